// File: rtl/arrhythmia_seq_ctrl.sv
// Purpose : sequencer and credit-based flow control in front of the non-stallable arrhythmia VAE datapath.
// Latency : a sample accepted at edge t is captured at edge t+PIPE_LAT and is visible on m_* right after that edge.
// Backpressure: s_ready is driven only from registers, and only while (in-flight + FIFO occupancy) < FIFO_DEPTH.
//
// Ports:
//   clk, reset           : clock; reset is synchronous and active-high
//   s_valid/s_ready/s_data : input vector stream (N_IN elements of BITSIZE bits, element 0 in the LSBs)
//   flush                : single-cycle request; discards in-flight and queued results
//   pipe_x / pipe_y      : datapath input vector and datapath output vector
//   m_valid/m_ready/m_data : result stream taken from the FIFO head (first-word fall-through)
//   m_class              : 1 when |element 1| > |element 0| of m_data
//   busy                 : flush active, sample in flight, or FIFO non-empty
//   err_ovf              : sticky FIFO-overflow flag
// Optional: define ARR_SEQ_CTRL_STATS_EN to add the saturating pop counters cnt_class0 and cnt_class1.
module arrhythmia_seq_ctrl #(
  parameter int BITSIZE    = 16,
  parameter int N_IN       = 10,
  parameter int N_OUT      = 2,
  parameter int PIPE_LAT   = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [BITSIZE*N_IN-1:0]    s_data,
  input  logic                       flush,
  output logic [BITSIZE*N_IN-1:0]    pipe_x,
  input  logic [BITSIZE*N_OUT-1:0]   pipe_y,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [BITSIZE*N_OUT-1:0]   m_data,
  output logic                       m_class,
  output logic                       busy,
  output logic                       err_ovf
`ifdef ARR_SEQ_CTRL_STATS_EN
  ,
  output logic [31:0]                cnt_class0,
  output logic [31:0]                cnt_class1
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PIPE_LAT);
  localparam int DW = BITSIZE * N_OUT;
  localparam logic [PW:0]   DEPTH_V = (PW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_TC  = CW'(PIPE_LAT - 1);

  typedef enum logic {ST_FLUSH = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [PIPE_LAT-1:0]      tok_q;
  logic [PW:0]              inflight_q;
  logic [PW:0]              wr_q, rd_q;
  logic [DW-1:0]            mem_q [FIFO_DEPTH];
  logic [BITSIZE*N_IN-1:0]  pipe_x_q;
  logic                     err_ovf_q;

  logic [PW:0]   fifo_cnt;
  logic [PW+1:0] occ;
  logic          empty, full;
  logic          accept, capture, clear, pop, push, wr_en;

  assign fifo_cnt = wr_q - rd_q;
  assign empty    = (wr_q == rd_q);
  assign full     = (fifo_cnt == DEPTH_V);
  assign occ      = {1'b0, inflight_q} + {1'b0, fifo_cnt};

  assign accept  = s_valid && s_ready;
  // Tokens only exist in RUN, so a token at the tail is always a live capture.
  assign capture = (state_q == ST_RUN) && tok_q[PIPE_LAT-1];
  // Flush in RUN and every FLUSH cycle wipe tokens, in-flight count and FIFO.
  assign clear   = flush || (state_q == ST_FLUSH);
  assign pop     = m_valid && m_ready;
  assign push    = capture && !clear;
  // When full, a simultaneous pop frees the head slot that the write then reuses.
  assign wr_en   = push && (!full || pop);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_ready = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        if (flush) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        s_ready = (occ < {1'b0, DEPTH_V});
        if (flush) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_FLUSH;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FLUSH;
      cnt_q      <= '0;
      tok_q      <= '0;
      inflight_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      pipe_x_q   <= '0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) pipe_x_q <= s_data;
      if (push && full && !pop) err_ovf_q <= 1'b1;
      if (clear) begin
        // An accept coinciding with flush still updates pipe_x but loses its token.
        tok_q      <= '0;
        inflight_q <= '0;
        wr_q       <= '0;
        rd_q       <= '0;
      end else begin
        tok_q <= {tok_q[PIPE_LAT-2:0], accept};
        case ({accept, capture})
          2'b10:   inflight_q <= inflight_q + (PW + 1)'(1);
          2'b01:   inflight_q <= inflight_q - (PW + 1)'(1);
          default: inflight_q <= inflight_q;
        endcase
        if (wr_en) wr_q <= wr_q + (PW + 1)'(1);
        if (pop)   rd_q <= rd_q + (PW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_q[PW-1:0]] <= pipe_y;
  end

  assign pipe_x  = pipe_x_q;
  assign err_ovf = err_ovf_q;
  assign m_valid = !empty;
  assign m_data  = mem_q[rd_q[PW-1:0]];
  // Sigmoid outputs are non-negative, so only magnitudes matter; ties go to class 0.
  assign m_class = (m_data[2*BITSIZE-2:BITSIZE] > m_data[BITSIZE-2:0]);
  assign busy    = (state_q == ST_FLUSH) || (inflight_q != '0) || !empty;

`ifdef ARR_SEQ_CTRL_STATS_EN
  logic [31:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (reset || ((state_q == ST_RUN) && flush)) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (pop) begin
      if (!m_class && (cnt0_q != '1)) cnt0_q <= cnt0_q + 32'd1;
      if (m_class && (cnt1_q != '1))  cnt1_q <= cnt1_q + 32'd1;
    end
  end

  assign cnt_class0 = cnt0_q;
  assign cnt_class1 = cnt1_q;
`endif

endmodule

// File: tb/tb_arrhythmia_seq_ctrl.sv
// Bench for arrhythmia_seq_ctrl with PIPE_LAT=5, FIFO_DEPTH=4 and a delay-line datapath y = {x[15:0], x[31:16]}.
module tb_arrhythmia_seq_ctrl;

  localparam int LAT = 5;
  localparam int DEP = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         s_valid = 1'b0;
  logic         flush = 1'b0;
  logic         m_ready = 1'b0;
  logic [159:0] s_data = '0;
  logic         s_ready, m_valid, m_class, busy, err_ovf;
  logic [159:0] pipe_x;
  logic [31:0]  pipe_y, m_data;
`ifdef ARR_SEQ_CTRL_STATS_EN
  logic [31:0]  cnt_class0, cnt_class1;
`endif

  always #5 clk = ~clk;

  arrhythmia_seq_ctrl #(
    .BITSIZE(16), .N_IN(10), .N_OUT(2), .PIPE_LAT(LAT), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .flush(flush), .pipe_x(pipe_x), .pipe_y(pipe_y), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_class(m_class), .busy(busy), .err_ovf(err_ovf)
`ifdef ARR_SEQ_CTRL_STATS_EN
    , .cnt_class0(cnt_class0), .cnt_class1(cnt_class1)
`endif
  );

  // Datapath stand-in: value on pipe_x after edge t appears on pipe_y just before edge t+LAT.
  logic [31:0] dl [LAT-1];
  always @(posedge clk) begin
    dl[0] <= {pipe_x[15:0], pipe_x[31:16]};
    for (int k = 1; k < LAT - 1; k++) dl[k] <= dl[k-1];
  end
  assign pipe_y = dl[LAT-2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] swp(input logic [31:0] x);
    return {x[15:0], x[31:16]};
  endfunction

  function automatic logic cls(input logic [31:0] y);
    logic [14:0] e1, e0;
    e1 = y[30:16];
    e0 = y[14:0];
    return (e1 > e0);
  endfunction

  // Reference model: pending samples carry the edge number at which they come out of the datapath.
  bit          chk_en = 1'b0;
  bit          md_run = 1'b0;
  int          md_left = LAT;
  int          ecount = 0;
  bit          md_err = 1'b0;
  logic [31:0] pend_y [$];
  int          pend_due [$];
  logic [31:0] fq [$];

  task automatic model_step();
    bit sr, acc, pp, cap, clr;
    logic [31:0] y;
    int d;
    ecount++;
    if (reset) begin
      md_run = 1'b0; md_left = LAT; md_err = 1'b0;
      pend_y.delete(); pend_due.delete(); fq.delete();
      chk_en = 1'b1;
      return;
    end
    sr  = md_run && ((pend_y.size() + fq.size()) < DEP);
    acc = s_valid && sr;
    pp  = (fq.size() > 0) && m_ready;
    cap = md_run && (pend_due.size() > 0) && (pend_due[0] == ecount);
    clr = flush || !md_run;
    if (clr) begin
      pend_y.delete(); pend_due.delete(); fq.delete();
    end else begin
      if (pp) y = fq.pop_front();
      if (cap) begin
        y = pend_y.pop_front();
        d = pend_due.pop_front();
        if (fq.size() < DEP) fq.push_back(y);
        else md_err = 1'b1;
      end
      if (acc) begin
        pend_y.push_back(swp(s_data[31:0]));
        pend_due.push_back(ecount + LAT);
      end
    end
    if (md_run) begin
      if (flush) begin md_run = 1'b0; md_left = LAT; end
    end else if (flush) begin
      md_left = LAT;
    end else begin
      md_left--;
      if (md_left == 0) md_run = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("s_ready", {31'b0, s_ready}, {31'b0, md_run && ((pend_y.size() + fq.size()) < DEP)});
      chk("busy", {31'b0, busy}, {31'b0, !md_run || (pend_y.size() > 0) || (fq.size() > 0)});
      chk("m_valid", {31'b0, m_valid}, {31'b0, fq.size() > 0});
      chk("err_ovf", {31'b0, err_ovf}, {31'b0, md_err});
      if (fq.size() > 0) begin
        chk("m_data", m_data, fq[0]);
        chk("m_class", {31'b0, m_class}, {31'b0, cls(fq[0])});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rnd_upper();
    for (int i = 1; i < 5; i++) s_data[i*32 +: 32] = $urandom();
  endtask

  // Launch one sample with the FIFO drained, report cycles to m_valid and the head, then pop it.
  task automatic send(input logic [31:0] lo, output int lat, output logic [31:0] md, output logic mc);
    int k;
    m_ready = 1'b0;
    rnd_upper();
    s_data[31:0] = lo;
    s_valid = 1'b1;
    k = 0;
    while (!s_ready && k < 50) begin step(); k++; end
    step();
    s_valid = 1'b0;
    lat = 0;
    while (!m_valid && lat < 50) begin step(); lat++; end
    md = m_data;
    mc = m_class;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, nacc, npop, mv, lat;
    logic [31:0] md, lo;
    logic mc;

    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Reset release: five closed-credit cycles.
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_mvalid", {31'b0, m_valid}, 32'd0);
    n = 0;
    while (!s_ready && n < 20) begin n++; step(); end
    chk("rst_sready_cycles", n, 32'd5);
    chk("run_busy", {31'b0, busy}, 32'd0);

    // Single sample and class decisions.
    send(32'h0200_0400, lat, md, mc);
    chk("single_lat", lat, 32'd5);
    chk("single_data", md, 32'h0400_0200);
    chk("single_class", {31'b0, mc}, 32'd1);
    send(32'h0155_0155, lat, md, mc);
    chk("tie_data", md, 32'h0155_0155);
    chk("tie_class", {31'b0, mc}, 32'd0);
    send(32'h0050_8100, lat, md, mc);
    chk("sign_data", md, 32'h8100_0050);
    chk("sign_class", {31'b0, mc}, 32'd1);

    // Backpressure: consumer stalled, producer always valid.
    m_ready = 1'b0;
    s_valid = 1'b1;
    nacc = 0;
    repeat (30) begin
      rnd_upper();
      s_data[31:0] = $urandom();
      if (s_ready) nacc++;
      step();
    end
    chk("bp_accepts", nacc, 32'd4);
    chk("bp_sready", {31'b0, s_ready}, 32'd0);
    s_valid = 1'b0;
    m_ready = 1'b1;
    npop = 0;
    repeat (20) begin
      if (m_valid) npop++;
      step();
    end
    chk("bp_pops", npop, 32'd4);
    chk("bp_sready_back", {31'b0, s_ready}, 32'd1);
    chk("bp_err", {31'b0, err_ovf}, 32'd0);

    // Flush with two samples in flight.
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data[31:0] = 32'h1111_2222; step();
    s_data[31:0] = 32'h3333_4444; step();
    s_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n = 0;
    mv = 0;
    while (!s_ready && n < 20) begin
      if (m_valid) mv++;
      n++;
      step();
    end
    repeat (8) begin
      if (m_valid) mv++;
      step();
    end
    chk("flush_sready_cycles", n, 32'd5);
    chk("flush_no_results", mv, 32'd0);
    lo = $urandom();
    send(lo, lat, md, mc);
    chk("post_flush_lat", lat, 32'd5);
    chk("post_flush_data", md, swp(lo));

    // Streaming with concurrent capture and pop at full credit occupancy.
    m_ready = 1'b1;
    s_valid = 1'b1;
    nacc = 0;
    npop = 0;
    n = 0;
    while (nacc < 12 && n < 200) begin
      s_data[31:0] = $urandom();
      if (s_ready) nacc++;
      if (m_valid) npop++;
      step();
      n++;
    end
    s_valid = 1'b0;
    repeat (20) begin
      if (m_valid) npop++;
      step();
    end
    chk("stream_accepts", nacc, 32'd12);
    chk("stream_pops", npop, 32'd12);
    chk("stream_err", {31'b0, err_ovf}, 32'd0);

    // Randomised traffic, flushes and one mid-run reset.
    for (int c = 0; c < 1500; c++) begin
      rnd_upper();
      s_data[31:0] = $urandom();
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = (c % 200 < 60) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 59) == 0);
      reset   = (c == 700 || c == 701);
      step();
    end
    s_valid = 1'b0;
    flush = 1'b0;
    reset = 1'b0;
    m_ready = 1'b1;
    repeat (20) step();
    chk("final_empty", {31'b0, m_valid}, 32'd0);
    chk("final_err", {31'b0, err_ovf}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
